// File: rtl/pipe_controller_if.sv
// Control-path bundle between the IF/ID register, the datapath stage muxes
// and pipe_controller.
interface pipe_controller_if #(
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
);
  logic                id_valid;
  logic [31:0]         id_instr;
  logic                branch_taken;
  logic                stall;
  logic                illegal;
  logic                ex_valid;
  logic                ex_imm_sel;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                mem_valid;
  logic                mem_write;
  logic                wb_lmd;
  logic                wb_aluout;
  logic                wb_reg_en;
  logic [REG_AW-1:0]   wb_rd;

  modport master (
    output id_valid, id_instr, branch_taken,
    input  stall, illegal, ex_valid, ex_imm_sel, ex_alu_op, fwd_a, fwd_b,
           mem_valid, mem_write, wb_lmd, wb_aluout, wb_reg_en, wb_rd
  );

  modport slave (
    input  id_valid, id_instr, branch_taken,
    output stall, illegal, ex_valid, ex_imm_sel, ex_alu_op, fwd_a, fwd_b,
           mem_valid, mem_write, wb_lmd, wb_aluout, wb_reg_en, wb_rd
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined RV32I control: ID decode, EX/MEM/WB control registers,
// load-use / RAW hazard stall, operand forwarding and branch flush.
module pipe_controller #(
  parameter bit FWD_EN   = 1'b1,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  pipe_controller_if.slave bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic                imm_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_write;
    logic                wb_lmd;
    logic                wb_aluout;
  } ctrl_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              alt;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              unused_instr_bits;

  assign opcode            = bus.id_instr[6:0];
  assign funct3            = bus.id_instr[14:12];
  assign alt               = bus.id_instr[30];
  assign id_rd             = REG_AW'(bus.id_instr[11:7]);
  assign id_rs1            = REG_AW'(bus.id_instr[19:15]);
  assign id_rs2            = REG_AW'(bus.id_instr[24:20]);
  assign unused_instr_bits = ^{bus.id_instr[31], bus.id_instr[29:25]};

  ctrl_t      id_ctrl;
  logic [4:0] alu_code;
  logic       id_illegal;
  logic       id_use1;
  logic       id_use2;
  logic       id_writes;

  always_comb begin
    id_ctrl    = '0;
    alu_code   = 5'd0;
    id_illegal = 1'b0;
    id_use1    = 1'b1;
    id_use2    = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        id_ctrl.imm_sel = 1'b1;
        id_ctrl.wb_lmd  = 1'b1;
        id_illegal      = (funct3 != 3'b010);
      end
      OPC_OPIMM: begin
        id_ctrl.imm_sel   = 1'b1;
        id_ctrl.wb_aluout = 1'b1;
        case (funct3)
          3'b101:  alu_code = alt ? 5'd7 : 5'd6;
          3'b110:  alu_code = 5'd8;
          3'b111:  alu_code = 5'd9;
          default: alu_code = {2'b00, funct3} + 5'd1;
        endcase
      end
      OPC_AUIPC: begin
        id_ctrl.imm_sel   = 1'b1;
        id_ctrl.wb_aluout = 1'b1;
        id_use1           = 1'b0;
        alu_code          = 5'd10;
      end
      OPC_STORE: begin
        id_ctrl.imm_sel   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_use2           = 1'b1;
        id_illegal        = (funct3 > 3'b010);
        alu_code          = 5'd11 + {2'b00, funct3};
      end
      OPC_OP: begin
        id_ctrl.wb_aluout = 1'b1;
        id_use2           = 1'b1;
        case (funct3)
          3'b000:  alu_code = alt ? 5'd15 : 5'd14;
          3'b101:  alu_code = alt ? 5'd21 : 5'd20;
          3'b110:  alu_code = 5'd22;
          3'b111:  alu_code = 5'd23;
          default: alu_code = {2'b00, funct3} + 5'd15;
        endcase
      end
      OPC_LUI: begin
        id_ctrl.imm_sel   = 1'b1;
        id_ctrl.wb_aluout = 1'b1;
        id_use1           = 1'b0;
        alu_code          = 5'd24;
      end
      OPC_BRANCH: begin
        id_use2 = 1'b1;
        case (funct3)
          3'b000:  alu_code = 5'd25;
          3'b001:  alu_code = 5'd26;
          3'b100:  alu_code = 5'd27;
          3'b101:  alu_code = 5'd28;
          3'b110:  alu_code = 5'd29;
          3'b111:  alu_code = 5'd30;
          default: id_illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        id_ctrl.imm_sel   = 1'b1;
        id_ctrl.wb_aluout = 1'b1;
        id_use1           = 1'b0;
        alu_code          = 5'd31;
      end
      default: id_illegal = 1'b1;
    endcase
    id_ctrl.alu_op = ALU_OP_W'(alu_code);
  end

  assign id_writes = id_ctrl.wb_lmd | id_ctrl.wb_aluout;

  logic              ex_valid_q, ex_valid_d;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic              mem_valid_q, mem_write_q, mem_lmd_q, mem_aluout_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_valid_q, wb_lmd_q, wb_aluout_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              illegal_q, illegal_d;

  // Stage index 0/1/2 = EX/MEM/WB; a stage "writes" only with a nonzero rd.
  logic [2:0]        stg_wr;
  logic [2:0]        stg_hit;
  logic [REG_AW-1:0] stg_rd [3];

  assign stg_wr[0] = ex_valid_q & (ex_ctrl_q.wb_lmd | ex_ctrl_q.wb_aluout) & (ex_rd_q != '0);
  assign stg_wr[1] = mem_valid_q & (mem_lmd_q | mem_aluout_q) & (mem_rd_q != '0);
  assign stg_wr[2] = wb_valid_q & (wb_lmd_q | wb_aluout_q) & (wb_rd_q != '0);
  assign stg_rd[0] = ex_rd_q;
  assign stg_rd[1] = mem_rd_q;
  assign stg_rd[2] = wb_rd_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign stg_hit[gi] = stg_wr[gi] &
                           ((id_use1 & (id_rs1 == stg_rd[gi])) |
                            (id_use2 & (id_rs2 == stg_rd[gi])));
    end
  endgenerate

  logic load_use;
  logic interlock;
  logic stall;

  assign load_use  = bus.id_valid & ex_valid_q & ex_ctrl_q.wb_lmd & stg_hit[0];
  assign interlock = bus.id_valid & (|stg_hit);
  assign stall     = ~bus.branch_taken & (load_use | (~FWD_EN & interlock));

  // EX source registers are zeroed when unused, so they never match a writing rd.
  logic [REG_AW-1:0] ex_rs   [2];
  logic [1:0]        fwd_sel [2];

  assign ex_rs[0] = ex_rs1_q;
  assign ex_rs[1] = ex_rs2_q;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = (!FWD_EN || !ex_valid_q)                    ? 2'b00 :
                           (stg_wr[1] && (stg_rd[1] == ex_rs[gi]))     ? 2'b01 :
                           (stg_wr[2] && (stg_rd[2] == ex_rs[gi]))     ? 2'b10 :
                                                                         2'b00;
    end
  endgenerate

  logic accept;

  always_comb begin
    accept     = bus.id_valid & ~bus.branch_taken & ~stall & ~id_illegal;
    ex_valid_d = accept;
    ex_ctrl_d  = accept ? id_ctrl : '0;
    ex_rd_d    = (accept && id_writes) ? id_rd : '0;
    ex_rs1_d   = (accept && id_use1) ? id_rs1 : '0;
    ex_rs2_d   = (accept && id_use2) ? id_rs2 : '0;
    illegal_d  = bus.id_valid & id_illegal & ~bus.branch_taken & ~stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_lmd_q    <= 1'b0;
      mem_aluout_q <= 1'b0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_lmd_q     <= 1'b0;
      wb_aluout_q  <= 1'b0;
      wb_rd_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      mem_valid_q  <= ex_valid_q;
      mem_write_q  <= ex_ctrl_q.mem_write;
      mem_lmd_q    <= ex_ctrl_q.wb_lmd;
      mem_aluout_q <= ex_ctrl_q.wb_aluout;
      mem_rd_q     <= ex_rd_q;
      wb_valid_q   <= mem_valid_q;
      wb_lmd_q     <= mem_lmd_q;
      wb_aluout_q  <= mem_aluout_q;
      wb_rd_q      <= mem_rd_q;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.illegal    = illegal_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_imm_sel = ex_ctrl_q.imm_sel;
  assign bus.ex_alu_op  = ex_ctrl_q.alu_op;
  assign bus.fwd_a      = fwd_sel[0];
  assign bus.fwd_b      = fwd_sel[1];
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.wb_lmd     = wb_lmd_q;
  assign bus.wb_aluout  = wb_aluout_q;
  assign bus.wb_reg_en  = stg_wr[2];
  assign bus.wb_rd      = wb_rd_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Drives a forwarding and an interlock controller with identical ID streams and
// checks both against a per-cycle timeline model of accepted instructions.
module tb_pipe_controller;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        branch_taken;

  pipe_controller_if #(.REG_AW(5), .ALU_OP_W(5)) fi ();
  pipe_controller_if #(.REG_AW(5), .ALU_OP_W(5)) li ();

  assign fi.id_valid     = id_valid;
  assign fi.id_instr     = id_instr;
  assign fi.branch_taken = branch_taken;
  assign li.id_valid     = id_valid;
  assign li.id_instr     = id_instr;
  assign li.branch_taken = branch_taken;

  pipe_controller #(.FWD_EN(1'b1), .REG_AW(5), .ALU_OP_W(5)) u_fwd (
    .clk(clk), .rst(rst), .bus(fi)
  );
  pipe_controller #(.FWD_EN(1'b0), .REG_AW(5), .ALU_OP_W(5)) u_ilk (
    .clk(clk), .rst(rst), .bus(li)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       ill;
    logic       imm;
    logic       mw;
    logic       lmd;
    logic       aw;
    logic       u1;
    logic       u2;
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } rec_t;

  // age[m][k]: instruction accepted into EX k+1 edges ago (mode 0 = fwd, 1 = ilk)
  rec_t  age [2][3];
  logic  ill_exp   [2];
  logic  stall_exp [2];
  string mn [2] = '{"fwd", "ilk"};

  int opimm_t [8] = '{1, 2, 3, 4, 5, 6, 8, 9};
  int op_t    [8] = '{14, 16, 17, 18, 19, 20, 22, 23};
  int br_t    [8] = '{25, 26, 0, 0, 27, 28, 29, 30};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic rec_t dec(input logic [31:0] ins);
    rec_t r;
    int   f3;
    logic b30;
    r   = '0;
    f3  = int'(ins[14:12]);
    b30 = ins[30];
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.u1  = 1'b1;
    case (ins[6:0])
      7'h03: begin r.ill = (f3 != 2); r.imm = 1; r.lmd = 1; end
      7'h13: begin r.op = 5'(opimm_t[f3] + ((f3 == 5 && b30) ? 1 : 0)); r.imm = 1; r.aw = 1; end
      7'h17: begin r.op = 5'd10; r.imm = 1; r.aw = 1; r.u1 = 0; end
      7'h23: begin r.ill = (f3 > 2); r.op = 5'(11 + f3); r.imm = 1; r.mw = 1; r.u2 = 1; end
      7'h33: begin r.op = 5'(op_t[f3] + (((f3 == 0 || f3 == 5) && b30) ? 1 : 0)); r.aw = 1; r.u2 = 1; end
      7'h37: begin r.op = 5'd24; r.imm = 1; r.aw = 1; r.u1 = 0; end
      7'h63: begin r.ill = (f3 == 2 || f3 == 3); r.op = 5'(br_t[f3]); r.u2 = 1; end
      7'h6F: begin r.op = 5'd31; r.imm = 1; r.aw = 1; r.u1 = 0; end
      default: r.ill = 1;
    endcase
    r.rd = (r.lmd || r.aw) ? ins[11:7] : 5'd0;
    return r;
  endfunction

  function automatic logic writes(input rec_t r);
    return r.v && (r.lmd || r.aw) && r.rd != 5'd0;
  endfunction

  function automatic logic reads(input rec_t d, input logic [4:0] r);
    return (d.u1 && d.rs1 == r) || (d.u2 && d.rs2 == r);
  endfunction

  function automatic logic [1:0] fsel(input int m, input logic [4:0] rs, input logic used);
    if (m != 0 || !age[m][0].v || !used) return 2'd0;
    if (writes(age[m][1]) && age[m][1].rd == rs) return 2'd1;
    if (writes(age[m][2]) && age[m][2].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mode(input string tag, input int m,
                            input logic stl, input logic ill, input logic exv, input logic exi,
                            input logic [4:0] exop, input logic [1:0] fa, input logic [1:0] fb,
                            input logic memv, input logic memw, input logic wl, input logic wa,
                            input logic wre, input logic [4:0] wrd);
    rec_t  d, ex, mm, wb;
    logic  lu, il, es;
    string p;
    p  = $sformatf("%s.%s", tag, mn[m]);
    d  = dec(id_instr);
    ex = age[m][0];
    mm = age[m][1];
    wb = age[m][2];
    lu = id_valid && ex.v && ex.lmd && ex.rd != 5'd0 && reads(d, ex.rd);
    il = id_valid && ((writes(ex) && reads(d, ex.rd)) ||
                      (writes(mm) && reads(d, mm.rd)) ||
                      (writes(wb) && reads(d, wb.rd)));
    es = !branch_taken && (lu || (m == 1 && il));
    stall_exp[m] = es;
    chk({p, ".stall"},      32'(stl),  32'(es));
    chk({p, ".illegal"},    32'(ill),  32'(ill_exp[m]));
    chk({p, ".ex_valid"},   32'(exv),  32'(ex.v));
    chk({p, ".ex_imm_sel"}, 32'(exi),  32'(ex.imm));
    chk({p, ".ex_alu_op"},  32'(exop), 32'(ex.op));
    chk({p, ".fwd_a"},      32'(fa),   32'(fsel(m, ex.rs1, ex.u1)));
    chk({p, ".fwd_b"},      32'(fb),   32'(fsel(m, ex.rs2, ex.u2)));
    chk({p, ".mem_valid"},  32'(memv), 32'(mm.v));
    chk({p, ".mem_write"},  32'(memw), 32'(mm.mw));
    chk({p, ".wb_lmd"},     32'(wl),   32'(wb.lmd));
    chk({p, ".wb_aluout"},  32'(wa),   32'(wb.aw));
    chk({p, ".wb_reg_en"},  32'(wre),  32'(writes(wb)));
    chk({p, ".wb_rd"},      32'(wrd),  32'(wb.rd));
  endtask

  task automatic check_all(input string tag);
    check_mode(tag, 0, fi.stall, fi.illegal, fi.ex_valid, fi.ex_imm_sel, fi.ex_alu_op,
               fi.fwd_a, fi.fwd_b, fi.mem_valid, fi.mem_write, fi.wb_lmd, fi.wb_aluout,
               fi.wb_reg_en, fi.wb_rd);
    check_mode(tag, 1, li.stall, li.illegal, li.ex_valid, li.ex_imm_sel, li.ex_alu_op,
               li.fwd_a, li.fwd_b, li.mem_valid, li.mem_write, li.wb_lmd, li.wb_aluout,
               li.wb_reg_en, li.wb_rd);
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) age[m][k] = '0;
      ill_exp[m]   = 1'b0;
      stall_exp[m] = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic bt, input string tag);
    id_valid     = v;
    id_instr     = ins;
    branch_taken = bt;
    @(negedge clk);
    check_all(tag);
    $display("step %-8s t=%0t valid=%0b instr=%08h bt=%0b stall f/i=%0b/%0b", tag, $time,
             v, ins, bt, fi.stall, li.stall);
  endtask

  task automatic tick();
    rec_t d;
    logic acc;
    @(posedge clk);
    d = dec(id_instr);
    for (int m = 0; m < 2; m++) begin
      acc          = id_valid && !branch_taken && !stall_exp[m] && !d.ill;
      ill_exp[m]   = id_valid && d.ill && !branch_taken && !stall_exp[m];
      age[m][2]    = age[m][1];
      age[m][1]    = age[m][0];
      age[m][0]    = '0;
      if (acc) begin
        age[m][0]   = d;
        age[m][0].v = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 1'b0, "idle");
      tick();
    end
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    model_clear();
    #1;
    check_all(tag);
    $display("reset %-8s t=%0t", tag, $time);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] I_ADD3   = 32'h002081B3;
  localparam logic [31:0] I_LW5    = 32'h0000A283;
  localparam logic [31:0] I_ADD6   = 32'h00528333;
  localparam logic [31:0] I_ADDI7  = 32'h00100393;
  localparam logic [31:0] I_ADD8   = 32'h00038433;
  localparam logic [31:0] I_ADDI1  = 32'h00100093;
  localparam logic [31:0] I_ADDI2  = 32'h00100113;
  localparam logic [31:0] I_ADDI3  = 32'h00100193;

  int          opcs [10] = '{'h03, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h6F, 'h67, 'h00};
  logic [31:0] rins;

  initial begin
    rst          = 1'b0;
    id_valid     = 1'b0;
    id_instr     = 32'h0;
    branch_taken = 1'b0;
    #1;
    apply_reset("por");

    // ADD x3,x1,x2 through the pipe
    drive(1'b1, I_ADD3, 1'b0, "add");      tick();
    drive(1'b0, 32'h0, 1'b0, "add_ex");
    chk("add.ex_alu_op", 32'(fi.ex_alu_op), 32'd14);
    chk("add.ex_imm_sel", 32'(fi.ex_imm_sel), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, "add_mem");  tick();
    drive(1'b0, 32'h0, 1'b0, "add_wb");
    chk("add.wb_reg_en", 32'(fi.wb_reg_en), 32'd1);
    chk("add.wb_rd", 32'(fi.wb_rd), 32'd3);
    chk("add.wb_aluout", 32'(fi.wb_aluout), 32'd1);
    tick();
    idle(2);

    // load-use: LW x5 then ADD x6,x5,x5
    drive(1'b1, I_LW5, 1'b0, "lw");       tick();
    drive(1'b1, I_ADD6, 1'b0, "lu_stl");
    chk("lu.stall", 32'(fi.stall), 32'd1);
    tick();
    drive(1'b1, I_ADD6, 1'b0, "lu_go");
    chk("lu.stall_rel", 32'(fi.stall), 32'd0);
    chk("lu.ex_bubble", 32'(fi.ex_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, "lu_fwd");
    chk("lu.fwd_a", 32'(fi.fwd_a), 32'd2);
    chk("lu.fwd_b", 32'(fi.fwd_b), 32'd2);
    tick();
    idle(4);

    // adjacent RAW: ADDI x7 then ADD x8,x7,x0 held in ID
    drive(1'b1, I_ADDI7, 1'b0, "addi7");  tick();
    drive(1'b1, I_ADD8, 1'b0, "raw1");
    chk("raw.fwd_stall", 32'(fi.stall), 32'd0);
    chk("raw.ilk_stall1", 32'(li.stall), 32'd1);
    tick();
    drive(1'b1, I_ADD8, 1'b0, "raw2");
    chk("raw.fwd_a", 32'(fi.fwd_a), 32'd1);
    chk("raw.ilk_stall2", 32'(li.stall), 32'd1);
    tick();
    drive(1'b1, I_ADD8, 1'b0, "raw3");
    chk("raw.ilk_stall3", 32'(li.stall), 32'd1);
    tick();
    drive(1'b1, I_ADD8, 1'b0, "raw4");
    chk("raw.ilk_stall4", 32'(li.stall), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, "raw5");
    chk("raw.ilk_fwd_a", 32'(li.fwd_a), 32'd0);
    tick();
    idle(4);

    // flush overrides load-use stall
    drive(1'b1, I_LW5, 1'b0, "fl_lw");    tick();
    drive(1'b1, I_ADD6, 1'b1, "flush");
    chk("flush.stall_f", 32'(fi.stall), 32'd0);
    chk("flush.stall_i", 32'(li.stall), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, "fl_after");
    chk("flush.ex_bubble", 32'(fi.ex_valid), 32'd0);
    chk("flush.mem_valid", 32'(fi.mem_valid), 32'd1);
    tick();
    idle(3);

    // illegal all-zero instruction, then the same flushed
    drive(1'b1, 32'h0, 1'b0, "ill");      tick();
    drive(1'b0, 32'h0, 1'b0, "ill_p1");
    chk("ill.pulse", 32'(fi.illegal), 32'd1);
    chk("ill.ex_bubble", 32'(fi.ex_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, "ill_p2");
    chk("ill.pulse_end", 32'(fi.illegal), 32'd0);
    tick();
    drive(1'b1, 32'h0, 1'b1, "ill_fl");   tick();
    drive(1'b0, 32'h0, 1'b0, "ill_flp");
    chk("ill.flushed", 32'(fi.illegal), 32'd0);
    tick();

    // fill all stages, then asynchronous reset between edges
    drive(1'b1, I_ADDI1, 1'b0, "fill1");  tick();
    drive(1'b1, I_ADDI2, 1'b0, "fill2");  tick();
    drive(1'b1, I_ADDI3, 1'b0, "fill3");  tick();
    id_valid = 1'b1;
    id_instr = I_ADD6;
    apply_reset("midrst");
    chk("midrst.wb_reg_en", 32'(fi.wb_reg_en), 32'd0);
    chk("midrst.mem_valid", 32'(li.mem_valid), 32'd0);
    idle(3);

    // randomized stream over a small register set to provoke hazards
    for (int k = 0; k < 400; k++) begin
      rins         = $urandom;
      rins[6:0]    = 7'(opcs[$urandom_range(0, 9)]);
      rins[11:7]   = 5'($urandom_range(0, 3));
      rins[19:15]  = 5'($urandom_range(0, 3));
      rins[24:20]  = 5'($urandom_range(0, 3));
      if (rins[6:0] == 7'h03 && $urandom_range(0, 3) != 0) rins[14:12] = 3'b010;
      drive($urandom_range(0, 9) < 8, rins, $urandom_range(0, 9) == 0, "rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
